uart_debug_ctrl: RTL and testbench

Parametrised UART debug controller for the OTTER CPU test harness. It receives framed 8N1 command bytes over a serial line, and from those commands it resets the CPU, single-steps it N times, or returns a full-width snapshot of the address, read-data or write-data bus. It replaces the free-running 1-byte debug UART with mid-bit sampling, start/stop-bit checking, multi-byte readback and multi-step commands. It sits between the host serial pins and the CPU clock/reset inputs.

---
 rtl/uart_debug_pkg.sv | 51 +++++
 rtl/uart_rx_byte.sv | 93 +++++++++
 rtl/uart_debug_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_uart_debug_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_debug_pkg.sv
// uart_debug_pkg
//   Shared types and constants for the UART debug controller:
//   command opcode / bus-select enums, receiver and control FSM state
//   encodings, frame length and the 8N1 frame bit helper.
package uart_debug_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RST  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_READ = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        SEL_ADDR  = 2'b00,
        SEL_RDATA = 2'b01,
        SEL_WDATA = 2'b10,
        SEL_NONE  = 2'b11
    } sel_e;

    // Receiver FSM encoding
    typedef logic [1:0] rx_state_e;
    localparam rx_state_e R_IDLE  = 2'd0;
    localparam rx_state_e R_START = 2'd1;
    localparam rx_state_e R_DATA  = 2'd2;
    localparam rx_state_e R_STOP  = 2'd3;

    // Control FSM encoding
    typedef logic [2:0] ctrl_state_e;
    localparam ctrl_state_e C_IDLE   = 3'd0;
    localparam ctrl_state_e C_DECODE = 3'd1;
    localparam ctrl_state_e C_RST    = 3'd2;
    localparam ctrl_state_e C_STEP   = 3'd3;
    localparam ctrl_state_e C_TX     = 3'd4;

    // start + 8 data + stop
    localparam int unsigned FRAME_BITS = 10;

    // Line level for bit position idx of an 8N1 frame carrying data.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] data);
        logic [3:0] k;
        k = idx - 4'd1;
        if (idx == 4'd0)
            return 1'b0;
        else if (idx <= 4'd8)
            return data[k[2:0]];
        else
            return 1'b1;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 serial receiver: 2-flop synchroniser, start-bit glitch rejection,
//   mid-bit sampling, stop-bit check. Framed bytes with a bad stop bit are
//   dropped; the receiver re-arms only on a fresh falling edge.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   rx     in   serial line (asynchronous, idles high)
//   data   out  last received byte (valid with / after the valid pulse)
//   valid  out  1-cycle pulse when a correctly framed byte completes
module uart_rx_byte
    import uart_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [1:0]       sync;
    logic             rx_d;
    logic             rx_s;
    rx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    assign rx_s = sync[1];
    assign data = shreg;

    // Re-arming uses a falling edge rather than a low level, so after a
    // framing error the line must return high before a new start is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '1;
            rx_d    <= 1'b1;
            state   <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            valid   <= 1'b0;
        end else begin
            sync  <= {sync[0], rx};
            rx_d  <= rx_s;
            valid <= 1'b0;
            case (state)
                R_IDLE: begin
                    if (rx_d && !rx_s) begin
                        state <= R_START;
                        cnt   <= '0;
                    end
                end
                R_START: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= R_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        state <= R_IDLE;
                        valid <= rx_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl
//   UART debug controller for the OTTER CPU harness. Receives 8N1 command
//   bytes ([1:0] opcode, [3:2] sel, [7:4] n) and resets the CPU, single-steps
//   it n+1 times, or returns a DATA_W-bit bus snapshot LSB byte first.
// Optional feature macro: UART_DEBUG_ECHO_EN -- echo each accepted command
//   byte as one frame ahead of any action or response.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   RX         in   serial command input
//   TX         out  serial response output (8N1, idles high)
//   cpu_clk    out  CPU clock, pulsed only during reset/step
//   cpu_rst    out  CPU reset, active high
//   bus_addr   in   CPU address bus
//   bus_rdata  in   CPU read-data bus
//   bus_wdata  in   CPU write-data bus
module uart_debug_ctrl
    import uart_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 32,
    parameter int RST_CYCLES   = 2,
    parameter int STEP_TICKS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    output logic              TX,
    output logic              cpu_clk,
    output logic              cpu_rst,
    input  logic [DATA_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic [DATA_W-1:0] bus_wdata
);

    localparam int NBYTES  = DATA_W / 8;
`ifdef UART_DEBUG_ECHO_EN
    localparam int ECHO    = 1;
`else
    localparam int ECHO    = 0;
`endif
    localparam int FR_W    = $clog2(NBYTES + 2);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int ST_W    = $clog2(STEP_TICKS + 1);
    localparam int PER_MAX = (RST_CYCLES > 16) ? RST_CYCLES : 16;
    localparam int PER_W   = $clog2(PER_MAX);

    logic [7:0]       rx_byte;
    logic             rx_valid;

    ctrl_state_e      state;
    logic [7:0]       cmd;
    logic [DATA_W-1:0] snap_addr, snap_rdata, snap_wdata;

    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [FR_W-1:0]  frame_idx;
    logic [FR_W-1:0]  frame_cnt;

    logic [ST_W-1:0]  ph_cnt;
    logic [PER_W-1:0] periods_left;

    cmd_e             opcode;
    sel_e             sel;
    logic             is_read_data;
    logic [FR_W-1:0]  dec_frames;
    logic [DATA_W-1:0] sel_word;
    logic [FR_W-1:0]  dbyte;
    logic [7:0]       data_byte;
    logic [7:0]       tx_byte;
    logic             tx_bit_end;
    logic             tx_last;
    ctrl_state_e      act_state;
    logic             start_action;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (RX),
        .data (rx_byte),
        .valid(rx_valid)
    );

    always_comb begin
        opcode       = cmd_e'(cmd[1:0]);
        sel          = sel_e'(cmd[3:2]);
        is_read_data = (opcode == CMD_READ) && (sel != SEL_NONE);
        dec_frames   = FR_W'(ECHO) + (is_read_data ? FR_W'(NBYTES) : '0);

        case (sel)
            SEL_ADDR:  sel_word = snap_addr;
            SEL_RDATA: sel_word = snap_rdata;
            default:   sel_word = snap_wdata;
        endcase

        // Data frames follow the optional echo frame.
        dbyte     = frame_idx - FR_W'(ECHO);
        data_byte = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (dbyte == FR_W'(i))
                data_byte = sel_word[8*i +: 8];
        end
`ifdef UART_DEBUG_ECHO_EN
        tx_byte = (frame_idx == '0) ? cmd : data_byte;
`else
        tx_byte = data_byte;
`endif

        tx_bit_end = (tx_cnt == CNT_W'(CLKS_PER_BIT - 1));
        tx_last    = (state == C_TX) && tx_bit_end &&
                     (tx_bit == 4'(FRAME_BITS - 1)) &&
                     (frame_idx == frame_cnt - 1'b1);

        case (opcode)
            CMD_RST:  act_state = C_RST;
            CMD_STEP: act_state = C_STEP;
            default:  act_state = C_IDLE;
        endcase

        // Actions run either straight from decode (nothing to send) or
        // after the last transmitted frame (echo ahead of RST/STEP).
        start_action = ((state == C_DECODE) && (dec_frames == '0)) || tx_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= C_IDLE;
            cmd          <= '0;
            snap_addr    <= '0;
            snap_rdata   <= '0;
            snap_wdata   <= '0;
            TX           <= 1'b1;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            frame_idx    <= '0;
            frame_cnt    <= '0;
            cpu_clk      <= 1'b0;
            cpu_rst      <= 1'b0;
            ph_cnt       <= '0;
            periods_left <= '0;
        end else begin
            case (state)
                C_IDLE: begin
                    if (rx_valid) begin
                        cmd   <= rx_byte;
                        state <= C_DECODE;
                    end
                end
                C_DECODE: begin
                    snap_addr  <= bus_addr;
                    snap_rdata <= bus_rdata;
                    snap_wdata <= bus_wdata;
                    frame_cnt  <= dec_frames;
                    frame_idx  <= '0;
                    if (dec_frames != '0) begin
                        state  <= C_TX;
                        TX     <= 1'b0;
                        tx_cnt <= '0;
                        tx_bit <= '0;
                    end
                end
                C_TX: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'(FRAME_BITS - 1)) begin
                            if (frame_idx == frame_cnt - 1'b1) begin
                                TX    <= 1'b1;
                                state <= C_IDLE;
                            end else begin
                                frame_idx <= frame_idx + 1'b1;
                                tx_bit    <= '0;
                                TX        <= 1'b0;
                            end
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            TX     <= frame_bit(tx_bit + 4'd1, tx_byte);
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                C_RST, C_STEP: begin
                    if (ph_cnt == ST_W'(STEP_TICKS - 1)) begin
                        ph_cnt <= '0;
                        if (cpu_clk) begin
                            cpu_clk <= 1'b0;
                        end else if (periods_left == '0) begin
                            cpu_rst <= 1'b0;
                            state   <= C_IDLE;
                        end else begin
                            periods_left <= periods_left - 1'b1;
                            cpu_clk      <= 1'b1;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                default: state <= C_IDLE;
            endcase

            if (start_action) begin
                state <= act_state;
                if (act_state != C_IDLE) begin
                    cpu_clk <= 1'b1;
                    cpu_rst <= (act_state == C_RST);
                    ph_cnt  <= '0;
                    periods_left <= (act_state == C_RST) ? PER_W'(RST_CYCLES - 1)
                                                         : PER_W'(cmd[7:4]);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_debug_ctrl.sv
module tb_uart_debug_ctrl;

    localparam int CPB = 16;
    localparam int ST  = 4;
`ifdef UART_DEBUG_ECHO_EN
    localparam int ECHO = 1;
`else
    localparam int ECHO = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] bus_addr;
    logic [31:0] bus_rdata;
    logic [31:0] bus_wdata;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_debug_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (32),
        .RST_CYCLES  (2),
        .STEP_TICKS  (ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .TX       (TX),
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .bus_addr (bus_addr),
        .bus_rdata(bus_rdata),
        .bus_wdata(bus_wdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- TX frame monitor ----------------
    typedef struct {
        logic [7:0]  b;
        int unsigned start;
        logic        start_ok;
        logic        stop_ok;
    } frame_t;
    frame_t fq[$];

    always begin
        frame_t fr;
        @(negedge clk);
        if (rst_n === 1'b1 && TX === 1'b0) begin
            fr.start = cyc;
            repeat (CPB / 2) @(negedge clk);
            fr.start_ok = (TX === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                fr.b[i] = TX;
            end
            repeat (CPB) @(negedge clk);
            fr.stop_ok = (TX === 1'b1);
            fq.push_back(fr);
        end
    end

    // ---------------- cpu_clk / cpu_rst monitor ----------------
    int rises = 0, rst_rises = 0, bad_phase = 0, rst_clks = 0;
    int hl = 0, low_run = 99;
    logic prev_cc = 1'b0;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            hl      = 0;
            low_run = 99;
        end else begin
            if (cpu_clk && !prev_cc) begin
                rises++;
                if (cpu_rst) rst_rises++;
                if (low_run < ST) bad_phase++;
                hl = 0;
            end
            if (!cpu_clk && prev_cc) begin
                if (hl != ST) bad_phase++;
                low_run = 0;
            end
            if (cpu_clk) hl++;
            else if (low_run < 99) low_run++;
            if (cpu_rst) rst_clks++;
        end
        prev_cc = cpu_clk;
    end

    // ---------------- rdata that changes every clock ----------------
    logic rdata_spin = 1'b0;
    function automatic logic [31:0] spin_val(input int unsigned c);
        return (c * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction
    always @(negedge clk) if (rdata_spin) bus_rdata = spin_val(cyc);

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge clk);
        end
        RX = stop;
        repeat (CPB) @(negedge clk);
        RX = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] wdata;
        int          nfr;
        logic [31:0] word;
        int          rises;
        int          rst_rises;
        int          rst_clks;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int b_r, b_rr, b_bad, b_rc, badfr;
        fq.delete();
        bus_addr  = v.addr;
        bus_rdata = v.rdata;
        bus_wdata = v.wdata;
        b_r = rises; b_rr = rst_rises; b_bad = bad_phase; b_rc = rst_clks;
        send_byte(v.cmd, 1'b1);
        repeat (1000) @(negedge clk);
        check({tag, "_nframes"}, fq.size(), v.nfr + ECHO);
        if (fq.size() == v.nfr + ECHO) begin
`ifdef UART_DEBUG_ECHO_EN
            check({tag, "_echo"}, {24'h0, fq[0].b}, {24'h0, v.cmd});
`endif
            for (int j = 0; j < v.nfr; j++)
                check($sformatf("%s_byte%0d", tag, j), {24'h0, fq[j + ECHO].b},
                      {24'h0, v.word[8*j +: 8]});
        end
        badfr = 0;
        for (int j = 0; j < fq.size(); j++) begin
            if (!fq[j].start_ok || !fq[j].stop_ok) badfr++;
            if (j > 0 && fq[j].start - fq[j-1].start != 10 * CPB) badfr++;
        end
        check({tag, "_frame_shape"}, badfr, 0);
        check({tag, "_rises"}, rises - b_r, v.rises);
        check({tag, "_rst_rises"}, rst_rises - b_rr, v.rst_rises);
        check({tag, "_rst_clks"}, rst_clks - b_rc, v.rst_clks);
        check({tag, "_phase"}, bad_phase - b_bad, 0);
        check({tag, "_end_state"}, {29'h0, TX, cpu_clk, cpu_rst}, 32'h4);
    endtask

    // ---------------- test ----------------
    vec_t vecs[11];

    initial begin
        int t, b_r;
        frame_t f0;

        //            cmd    addr          rdata         wdata         nfr word          rise rr rclk
        vecs[0]  = '{8'h03, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 4, 32'h1234_5678, 0,  0, 0};
        vecs[1]  = '{8'h07, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 4, 32'hDEAD_BEEF, 0,  0, 0};
        vecs[2]  = '{8'h0B, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 4, 32'hA5C3_0F96, 0,  0, 0};
        vecs[3]  = '{8'h0F, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 0, 32'h0,         0,  0, 0};
        vecs[4]  = '{8'h00, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 0, 32'h0,         0,  0, 0};
        vecs[5]  = '{8'h32, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 0, 32'h0,         4,  0, 0};
        vecs[6]  = '{8'h02, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 0, 32'h0,         1,  0, 0};
        vecs[7]  = '{8'hF2, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 0, 32'h0,         16, 0, 0};
        vecs[8]  = '{8'h01, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 0, 32'h0,         2,  2, 16};
        vecs[9]  = '{8'hF1, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5C3_0F96, 0, 32'h0,         2,  2, 16};
        vecs[10] = '{8'h13, 32'h0000_00FF, 32'hDEAD_BEEF, 32'hA5C3_0F96, 4, 32'h0000_00FF, 0,  0, 0};

        RX = 1'b1; rst_n = 1'b0;
        bus_addr = '0; bus_rdata = '0; bus_wdata = '0;
        repeat (5) @(negedge clk);
        check("reset_outputs", {29'h0, TX, cpu_clk, cpu_rst}, 32'h4);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_outputs", {29'h0, TX, cpu_clk, cpu_rst}, 32'h4);

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], $sformatf("v%0d_cmd%02h", i, vecs[i].cmd));

        // Start-bit glitch: no byte, nothing moves.
        fq.delete();
        b_r = rises;
        @(negedge clk); RX = 1'b0;
        repeat (5) @(negedge clk); RX = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_no_tx", fq.size(), 0);
        check("glitch_no_cpu_clk", rises - b_r, 0);

        // Framing error: READ rdata with stop bit 0 must be dropped.
        send_byte(8'h07, 1'b0);
        repeat (800) @(negedge clk);
        check("framing_dropped", fq.size(), 0);
        run_vec('{8'h03, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hA5C3_0F96, 4, 32'hCAFE_F00D, 0, 0, 0},
                "after_frame_err");

        // Snapshot of a bus that changes every clock; second command mid-response ignored.
        fq.delete();
        b_r = rises;
        rdata_spin = 1'b1;
        send_byte(8'h07, 1'b1);
        send_byte(8'h32, 1'b1);
        repeat (1000) @(negedge clk);
        rdata_spin = 1'b0;
        check("spin_nframes", fq.size(), 4 + ECHO);
        check("spin_ignored_step", rises - b_r, 0);
        if (fq.size() == 4 + ECHO) begin
            f0 = fq[0];
            check("spin_snapshot",
                  {fq[ECHO+3].b, fq[ECHO+2].b, fq[ECHO+1].b, fq[ECHO].b},
                  spin_val(f0.start - 1));
        end

        // Reset in the middle of a READ response.
        fq.delete();
        bus_addr = 32'h1234_5678;
        send_byte(8'h03, 1'b1);
        t = 0;
        while (fq.size() == 0 && t < 800) begin @(negedge clk); t++; end
        check("mid_rsp_first_frame", (fq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        t = 0;
        while (TX !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        check("mid_rsp_tx_low", {31'h0, TX}, 32'h0);
        #2 rst_n = 1'b0;
        #1 check("tx_async_reset", {31'h0, TX}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a STEP burst.
        repeat (50) @(negedge clk);
        send_byte(8'hF2, 1'b1);
        t = 0;
        while (cpu_clk !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        check("mid_step_cpu_clk_high", {31'h0, cpu_clk}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check("cpu_clk_async_reset", {30'h0, cpu_clk, cpu_rst}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b_r = rises;
        repeat (300) @(negedge clk);
        check("post_reset_quiet", rises - b_r, 0);
        fq.delete();
        run_vec('{8'h03, 32'h8765_4321, 32'hDEAD_BEEF, 32'hA5C3_0F96, 4, 32'h8765_4321, 0, 0, 0},
                "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
